// File: rtl/cycler_pkg.sv
// Shared constants and helpers for the pattern cycler and related button-driven steppers.
package cycler_pkg;

  localparam int DEF_N_STATES = 4;
  localparam int DEF_OUT_W    = 3;

  // Entry i sits at bits [i*OUT_W +: OUT_W]; entries are 0, 2, 5, 7.
  localparam logic [DEF_N_STATES*DEF_OUT_W-1:0] DEF_PATTERN = {3'b111, 3'b101, 3'b010, 3'b000};

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_STEP
  } act_e;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by a rising-edge detector.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_in,
  output logic step
);

  logic [STAGES-1:0] s_q;
  logic [STAGES-1:0] s_d;
  logic              prev_q;
  logic              prev_d;

  always_comb begin
    s_d    = {s_q[STAGES-2:0], a_in};
    prev_d = s_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q    <= '0;
      prev_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      prev_q <= prev_d;
    end
  end

  assign step = s_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pattern_cycler.sv
// Steps an index through N_STATES positions on each synchronised rising edge of nxt,
// driving a registered code looked up from PATTERN.
module pattern_cycler
  import cycler_pkg::*;
#(
  parameter int                         N_STATES    = DEF_N_STATES,
  parameter int                         OUT_W       = DEF_OUT_W,
  parameter logic [N_STATES*OUT_W-1:0]  PATTERN     = DEF_PATTERN,
  parameter bit                         WRAP        = 1'b1,
  parameter int                         SYNC_STAGES = 2,
  localparam int                        IDX_W       = idx_width(N_STATES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             nxt,
  input  logic             dir,
  input  logic             ld,
  input  logic [IDX_W-1:0] ld_idx,
  output logic [IDX_W-1:0] idx,
  output logic [OUT_W-1:0] out_num,
  output logic             lim
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_STATES - 1);

  logic             step;
  act_e             act;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_num_q, out_num_d;
  logic             lim_q, lim_d;
  logic [IDX_W:0]   stepped;

  function automatic logic [OUT_W-1:0] pat(input logic [IDX_W-1:0] i);
    return PATTERN[int'(i)*OUT_W +: OUT_W];
  endfunction

  // Returns {lim, next index}; ends are detected by compare, never by overflow.
  function automatic logic [IDX_W:0] step_idx(input logic [IDX_W-1:0] cur, input logic d);
    logic [IDX_W-1:0] nxt_i;
    logic             hit;
    nxt_i = cur;
    hit   = 1'b0;
    if (d == DIR_FWD) begin
      if (cur == LAST) begin
        hit = 1'b1;
        if (WRAP) nxt_i = '0;
      end else begin
        nxt_i = cur + IDX_W'(1);
      end
    end else begin
      if (cur == '0) begin
        hit = 1'b1;
        if (WRAP) nxt_i = LAST;
      end else begin
        nxt_i = cur - IDX_W'(1);
      end
    end
    return {hit, nxt_i};
  endfunction

  sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .a_in  (nxt),
    .step  (step)
  );

  always_comb begin
    act = ACT_HOLD;
    if (ld)        act = ACT_LOAD;
    else if (step) act = ACT_STEP;
  end

  always_comb begin
    idx_d     = idx_q;
    out_num_d = out_num_q;
    lim_d     = 1'b0;
    stepped   = step_idx(idx_q, dir);
    case (act)
      ACT_LOAD: begin
        if (ld_idx <= LAST) begin
          idx_d     = ld_idx;
          out_num_d = pat(ld_idx);
        end
      end
      ACT_STEP: begin
        idx_d     = stepped[IDX_W-1:0];
        lim_d     = stepped[IDX_W];
        out_num_d = pat(stepped[IDX_W-1:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q     <= '0;
      out_num_q <= PATTERN[OUT_W-1:0];
      lim_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      out_num_q <= out_num_d;
      lim_q     <= lim_d;
    end
  end

  assign idx     = idx_q;
  assign out_num = out_num_q;
  assign lim     = lim_q;

endmodule

// File: tb/tb_pattern_cycler.sv
// Bench for pattern_cycler: three configurations share one stimulus stream, each phase checks one of them.
module tb_pattern_cycler;

  localparam logic [14:0] PAT_B = {3'd5, 3'd2, 3'd7, 3'd4, 3'd1};
  localparam logic [8:0]  PAT_C = {3'd1, 3'd3, 3'd6};

  localparam int K_RST   = 0;
  localparam int K_PULSE = 1;
  localparam int K_LD    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       nxt = 1'b0;
  logic       dir = 1'b0;
  logic       ld = 1'b0;
  logic [2:0] ld_idx = 3'd0;

  logic [1:0] idx_a, idx_c;
  logic [2:0] idx_b;
  logic [2:0] out_a, out_b, out_c;
  logic       lim_a, lim_b, lim_c;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int         unit;
    int         kind;
    logic       d;
    int         hold;
    logic [2:0] ldv;
    logic [2:0] e_idx;
    logic [2:0] e_out;
    logic       e_lim;
  } vec_t;

  typedef struct {
    int         due;
    int         unit;
    logic [2:0] idx;
    logic [2:0] out;
    logic       lim;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  pattern_cycler u_a (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .dir(dir), .ld(ld), .ld_idx(ld_idx[1:0]),
    .idx(idx_a), .out_num(out_a), .lim(lim_a)
  );

  pattern_cycler #(.N_STATES(5), .OUT_W(3), .PATTERN(PAT_B), .WRAP(1'b0), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .dir(dir), .ld(ld), .ld_idx(ld_idx),
    .idx(idx_b), .out_num(out_b), .lim(lim_b)
  );

  pattern_cycler #(.N_STATES(3), .OUT_W(3), .PATTERN(PAT_C), .WRAP(1'b1), .SYNC_STAGES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .dir(dir), .ld(ld), .ld_idx(ld_idx[1:0]),
    .idx(idx_c), .out_num(out_c), .lim(lim_c)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int due, input int u, input logic [2:0] i,
                          input logic [2:0] o, input logic l, input string nm);
    exp_t e;
    e.due = due; e.unit = u; e.idx = i; e.out = o; e.lim = l; e.name = nm;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: compares every expectation that falls due at this falling edge.
  always @(negedge clk) begin
    exp_t       e;
    logic [2:0] a_idx, a_out;
    logic       a_lim;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      case (e.unit)
        0:       begin a_idx = {1'b0, idx_a}; a_out = out_a; a_lim = lim_a; end
        1:       begin a_idx = idx_b;         a_out = out_b; a_lim = lim_b; end
        default: begin a_idx = {1'b0, idx_c}; a_out = out_c; a_lim = lim_c; end
      endcase
      n_tests++;
      if (e.due != cyc) begin
        n_fail++;
        $display("FAIL %s: check due at cycle %0d reached late at cycle %0d", e.name, e.due, cyc);
      end else if (a_idx !== e.idx || a_out !== e.out || a_lim !== e.lim) begin
        n_fail++;
        $display("FAIL %s: unit %0d cycle %0d got idx=%0d out=%0d lim=%0b, expected idx=%0d out=%0d lim=%0b",
                 e.name, e.unit, cyc, a_idx, a_out, a_lim, e.idx, e.out, e.lim);
      end
    end
  end

  task automatic do_rst(input int u, input logic [2:0] eo, input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    push_exp(cyc + 1, u, 3'd0, eo, 1'b0, nm);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_pulse(input int u, input logic d, input int hold, input logic [2:0] ei,
                          input logic [2:0] eo, input logic el, input string nm);
    int c;
    @(negedge clk);
    c   = cyc;
    dir = d;
    nxt = 1'b1;
    push_exp(c + 3, u, ei, eo, el, nm);
    push_exp(c + 4, u, ei, eo, 1'b0, {nm, "_after"});
    if (hold > 2) push_exp(c + hold + 2, u, ei, eo, 1'b0, {nm, "_held"});
    repeat (hold) @(negedge clk);
    nxt = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_ld(input int u, input logic [2:0] v, input logic [2:0] ei,
                       input logic [2:0] eo, input string nm);
    @(negedge clk);
    ld     = 1'b1;
    ld_idx = v;
    push_exp(cyc + 1, u, ei, eo, 1'b0, nm);
    @(negedge clk);
    ld = 1'b0;
  endtask

  initial begin
    int c;
    string nm;

    // unit, kind, dir, hold, ld value, expected idx, out, lim
    vecs.push_back('{0, K_RST,   1'b0, 0,  3'd0, 3'd0, 3'd0, 1'b0});
    vecs.push_back('{0, K_PULSE, 1'b0, 3,  3'd0, 3'd1, 3'd2, 1'b0});
    vecs.push_back('{0, K_PULSE, 1'b0, 3,  3'd0, 3'd2, 3'd5, 1'b0});
    vecs.push_back('{0, K_PULSE, 1'b0, 3,  3'd0, 3'd3, 3'd7, 1'b0});
    vecs.push_back('{0, K_PULSE, 1'b0, 3,  3'd0, 3'd0, 3'd0, 1'b1});
    vecs.push_back('{0, K_RST,   1'b0, 0,  3'd0, 3'd0, 3'd0, 1'b0});
    vecs.push_back('{0, K_PULSE, 1'b1, 3,  3'd0, 3'd3, 3'd7, 1'b1});
    vecs.push_back('{0, K_PULSE, 1'b1, 3,  3'd0, 3'd2, 3'd5, 1'b0});
    vecs.push_back('{0, K_PULSE, 1'b0, 20, 3'd0, 3'd3, 3'd7, 1'b0});
    vecs.push_back('{0, K_LD,    1'b0, 0,  3'd2, 3'd2, 3'd5, 1'b0});
    vecs.push_back('{1, K_RST,   1'b0, 0,  3'd0, 3'd0, 3'd1, 1'b0});
    vecs.push_back('{1, K_PULSE, 1'b0, 3,  3'd0, 3'd1, 3'd4, 1'b0});
    vecs.push_back('{1, K_PULSE, 1'b0, 3,  3'd0, 3'd2, 3'd7, 1'b0});
    vecs.push_back('{1, K_PULSE, 1'b0, 3,  3'd0, 3'd3, 3'd2, 1'b0});
    vecs.push_back('{1, K_PULSE, 1'b0, 3,  3'd0, 3'd4, 3'd5, 1'b0});
    vecs.push_back('{1, K_PULSE, 1'b0, 3,  3'd0, 3'd4, 3'd5, 1'b1});
    vecs.push_back('{1, K_PULSE, 1'b0, 3,  3'd0, 3'd4, 3'd5, 1'b1});
    vecs.push_back('{1, K_LD,    1'b0, 0,  3'd0, 3'd0, 3'd1, 1'b0});
    vecs.push_back('{1, K_PULSE, 1'b1, 3,  3'd0, 3'd0, 3'd1, 1'b1});
    vecs.push_back('{1, K_LD,    1'b0, 0,  3'd7, 3'd0, 3'd1, 1'b0});
    vecs.push_back('{1, K_LD,    1'b0, 0,  3'd4, 3'd4, 3'd5, 1'b0});
    vecs.push_back('{1, K_PULSE, 1'b1, 3,  3'd0, 3'd3, 3'd2, 1'b0});
    vecs.push_back('{2, K_RST,   1'b0, 0,  3'd0, 3'd0, 3'd6, 1'b0});
    vecs.push_back('{2, K_LD,    1'b0, 0,  3'd2, 3'd2, 3'd1, 1'b0});
    vecs.push_back('{2, K_LD,    1'b0, 0,  3'd3, 3'd2, 3'd1, 1'b0});
    vecs.push_back('{2, K_PULSE, 1'b0, 3,  3'd0, 3'd0, 3'd6, 1'b1});
    vecs.push_back('{2, K_PULSE, 1'b1, 3,  3'd0, 3'd2, 3'd1, 1'b1});
    vecs.push_back('{2, K_LD,    1'b0, 0,  3'd1, 3'd1, 3'd3, 1'b0});

    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      nm = $sformatf("vec%0d", i);
      case (vecs[i].kind)
        K_RST:   do_rst(vecs[i].unit, vecs[i].e_out, nm);
        K_PULSE: do_pulse(vecs[i].unit, vecs[i].d, vecs[i].hold, vecs[i].e_idx,
                          vecs[i].e_out, vecs[i].e_lim, nm);
        default: do_ld(vecs[i].unit, vecs[i].ldv, vecs[i].e_idx, vecs[i].e_out, nm);
      endcase
    end

    // ld coinciding with a step: load wins and the step is discarded, not deferred.
    do_rst(0, 3'd0, "prio_rst");
    @(negedge clk);
    c   = cyc;
    dir = 1'b0;
    nxt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ld     = 1'b1;
    ld_idx = 3'd2;
    push_exp(c + 3, 0, 3'd2, 3'd5, 1'b0, "prio_ld");
    push_exp(c + 4, 0, 3'd2, 3'd5, 1'b0, "prio_no_step");
    @(negedge clk);
    ld = 1'b0;
    repeat (3) @(negedge clk);
    nxt = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-sequence at idx 2 with nxt held high through release.
    do_rst(0, 3'd0, "mid_rst0");
    do_pulse(0, 1'b0, 3, 3'd1, 3'd2, 1'b0, "mid_s1");
    do_pulse(0, 1'b0, 3, 3'd2, 3'd5, 1'b0, "mid_s2");
    @(negedge clk);
    c     = cyc;
    nxt   = 1'b1;
    rst_n = 1'b0;
    push_exp(c + 1,  0, 3'd0, 3'd0, 1'b0, "mid_rst");
    push_exp(c + 2,  0, 3'd0, 3'd0, 1'b0, "mid_refill1");
    push_exp(c + 3,  0, 3'd0, 3'd0, 1'b0, "mid_refill2");
    push_exp(c + 4,  0, 3'd1, 3'd2, 1'b0, "mid_step");
    push_exp(c + 5,  0, 3'd1, 3'd2, 1'b0, "mid_after");
    push_exp(c + 12, 0, 3'd1, 3'd2, 1'b0, "mid_held");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    nxt = 1'b0;

    repeat (8) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: check due at cycle %0d never evaluated (now %0d)", e.name, e.due, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
